// File: rtl/keyrom_pkg.sv
// Shared types and default key contents for the key stream ROM.
// Lockout behaviour is selected in the top by the KEYROM_LOCKOUT_EN macro.
package keyrom_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int unsigned KEY_INIT_WORDS = 8;

    // Key 0 occupies words 0..3, key 1 occupies words 4..7.
    localparam logic [15:0] KEY_INIT [KEY_INIT_WORDS] = '{
        16'h0123, 16'h4567, 16'h89ab, 16'hcdef,
        16'hfedc, 16'hba98, 16'h7654, 16'h3210
    };

    function automatic logic [15:0] key_word(input int unsigned addr);
        if (addr < KEY_INIT_WORDS) begin
            return KEY_INIT[addr[2:0]];
        end
        return 16'h0000;
    endfunction

endpackage

// File: rtl/key_stream_rom_key_mem.sv
// Key storage: constant ROM array with a registered word address and combinational read.
// Contents come from keyrom_pkg and are never touched by reset; only the address register is.
module key_mem
    import keyrom_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [AW-1:0]     load_addr,
    input  logic              inc,
    output logic [DATA_W-1:0] data
);

    localparam int SLOTS = 2 ** AW;

    logic [DATA_W-1:0] rom [SLOTS];
    logic [AW-1:0]     addr_q;

    for (genvar i = 0; i < SLOTS; i++) begin : g_rom
        assign rom[i] = (i < DEPTH) ? DATA_W'(key_word(i)) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else if (load) begin
            addr_q <= load_addr;
        end else if (inc) begin
            addr_q <= addr_q + AW'(1);
        end
    end

    assign data = rom[addr_q];

endmodule

// File: rtl/key_stream_rom.sv
// Streams one stored key word-by-word under a valid/ready handshake, gated by acc_en.
// Define KEYROM_LOCKOUT_EN to make every error sticky (LOCKED until reset).
module key_stream_rom
    import keyrom_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int KEY_WORDS = 4,
    parameter int NUM_KEYS  = 2,
    parameter int IDX_W     = 1
) (
    input  logic              rom_clk,
    input  logic              rom_rst_n,
    input  logic              acc_en,
    input  logic              req_valid,
    input  logic [IDX_W-1:0]  req_idx,
    output logic              req_ready,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              dout_last,
    input  logic              dout_ready,
    output logic              err
);

    localparam int DEPTH = NUM_KEYS * KEY_WORDS;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
    localparam logic [CW-1:0]    LAST_CNT   = CW'(KEY_WORDS - 1);
    localparam logic [IDX_W:0]   NUM_KEYS_L = (IDX_W + 1)'(NUM_KEYS);

`ifdef KEYROM_LOCKOUT_EN
    localparam state_t ERR_STATE = LOCKED;
`else
    localparam state_t ERR_STATE = IDLE;
`endif

    state_t            state;
    logic [CW-1:0]     wcnt;
    logic [CW-1:0]     wcnt_nxt;
    logic [AW-1:0]     base_addr;
    logic [DATA_W-1:0] mem_data;
    logic              idx_ok;
    logic              load;
    logic              inc;

    assign idx_ok    = {1'b0, req_idx} < NUM_KEYS_L;
    assign base_addr = AW'(AW'(req_idx) * AW'(KEY_WORDS));
    assign wcnt_nxt  = wcnt + CW'(1);
    assign load      = (state == IDLE) && req_valid && acc_en && idx_ok;
    // An acc_en drop wins over any handshake, so the address only moves while access is held.
    assign inc       = (state == STREAM) && acc_en && dout_ready && !dout_last;

    key_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_key_mem (
        .clk       (rom_clk),
        .rst_n     (rom_rst_n),
        .load      (load),
        .load_addr (base_addr),
        .inc       (inc),
        .data      (mem_data)
    );

    always_ff @(posedge rom_clk) begin
        if (!rom_rst_n) begin
            state      <= IDLE;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            err        <= 1'b0;
            wcnt       <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (acc_en && idx_ok) begin
                            state      <= STREAM;
                            dout_valid <= 1'b1;
                            dout_last  <= (KEY_WORDS == 1);
                            wcnt       <= '0;
                        end else begin
                            state <= ERR_STATE;
                            err   <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (!acc_en) begin
                        state      <= ERR_STATE;
                        dout_valid <= 1'b0;
                        dout_last  <= 1'b0;
                        err        <= 1'b1;
                    end else if (dout_ready) begin
                        if (dout_last) begin
                            state      <= IDLE;
                            dout_valid <= 1'b0;
                            dout_last  <= 1'b0;
                        end else begin
                            wcnt      <= wcnt_nxt;
                            dout_last <= (wcnt_nxt == LAST_CNT);
                        end
                    end
                end
                LOCKED: begin
                    if (req_valid) begin
                        err <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state != STREAM);
    assign dout      = dout_valid ? mem_data : '0;

endmodule

// File: tb/tb_key_stream_rom.sv
// Self-checking bench for key_stream_rom: vector table plus hand sequences for abort and reset.
module tb_key_stream_rom;

    localparam int DW = 16;
    localparam int KW = 4;
    localparam int NK = 2;
    localparam int IW = 2;

    logic          rom_clk = 1'b0;
    logic          rom_rst_n = 1'b0;
    logic          acc_en = 1'b0;
    logic          req_valid = 1'b0;
    logic [IW-1:0] req_idx = '0;
    logic          req_ready;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_last;
    logic          dout_ready = 1'b0;
    logic          err;

    key_stream_rom #(
        .DATA_W    (DW),
        .KEY_WORDS (KW),
        .NUM_KEYS  (NK),
        .IDX_W     (IW)
    ) dut (
        .rom_clk    (rom_clk),
        .rom_rst_n  (rom_rst_n),
        .acc_en     (acc_en),
        .req_valid  (req_valid),
        .req_idx    (req_idx),
        .req_ready  (req_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_last  (dout_last),
        .dout_ready (dout_ready),
        .err        (err)
    );

    always #5 rom_clk = ~rom_clk;

    localparam logic [15:0] KEYS [8] = '{
        16'h0123, 16'h4567, 16'h89ab, 16'hcdef,
        16'hfedc, 16'hba98, 16'h7654, 16'h3210
    };

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } exp_t;

    typedef struct {
        logic [1:0] idx;
        logic       acc;
        bit         stall;
        bit         ok;
    } vec_t;

    exp_t exp_q [$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   err_cnt = 0;
    bit   mon_en = 1'b0;

    logic          prev_valid, prev_ready, prev_last, prev_acc, prev_rst;
    logic [DW-1:0] prev_dout;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_word(input int idx, input int w);
        return KEYS[idx * KW + w];
    endfunction

    // Scoreboard monitor: pops an expected word on every real handshake.
    always @(negedge rom_clk) begin
        if (mon_en) begin
            if (err === 1'b1) err_cnt++;
            if (dout_valid === 1'b0) check("dout_zero_when_idle", 32'(dout), 32'h0);
            if (prev_valid === 1'b1 && prev_ready === 1'b0 && prev_acc === 1'b1 && prev_rst === 1'b1) begin
                check("stall_dout_stable", 32'(dout), 32'(prev_dout));
                check("stall_valid_stable", 32'(dout_valid), 32'(prev_valid));
                check("stall_last_stable", 32'(dout_last), 32'(prev_last));
            end
            if (dout_valid === 1'b1 && dout_ready === 1'b1 && acc_en === 1'b1 && rom_rst_n === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(dout), 32'hffff_ffff);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("stream_word", 32'(dout), 32'(mon_e.d));
                    check("stream_last", 32'(dout_last), 32'(mon_e.l));
                end
            end
        end
        prev_valid = dout_valid;
        prev_ready = dout_ready;
        prev_last  = dout_last;
        prev_dout  = dout;
        prev_acc   = acc_en;
        prev_rst   = rom_rst_n;
    end

    task automatic do_reset();
        @(posedge rom_clk); #1;
        rom_rst_n  = 1'b0;
        req_valid  = 1'b0;
        dout_ready = 1'b0;
        acc_en     = 1'b1;
        @(posedge rom_clk); #1;
        @(posedge rom_clk); #1;
        rom_rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic do_req(input logic [1:0] idx, input logic acc, input bit stall, input bit ok);
        int c;
        @(posedge rom_clk); #1;
        req_valid  = 1'b1;
        req_idx    = idx;
        acc_en     = acc;
        dout_ready = !stall;
        if (ok) begin
            for (int w = 0; w < KW; w++) exp_q.push_back('{d: exp_word(idx, w), l: (w == KW - 1)});
        end
        @(negedge rom_clk);
        check("req_ready_before_accept", 32'(req_ready), 32'h1);
        @(posedge rom_clk); #1;
        req_valid = 1'b0;
        acc_en    = 1'b1;
        @(negedge rom_clk);
        if (ok) begin
            check("first_word_latency", 32'(dout_valid), 32'h1);
            check("no_err_on_good_req", 32'(err), 32'h0);
        end else begin
            check("err_pulse", 32'(err), 32'h1);
            check("no_stream_on_err", 32'(dout_valid), 32'h0);
        end
        c = 0;
        while (exp_q.size() > 0 && c < 40) begin
            @(posedge rom_clk); #1;
            if (stall) dout_ready = ~dout_ready;
            c++;
        end
        if (exp_q.size() > 0) begin
            check("stream_timeout", 32'(exp_q.size()), 32'h0);
            exp_q.delete();
        end
        if (ok && !stall) check("no_bubble_cycles", 32'(c), 32'(KW));
        @(negedge rom_clk);
        check("err_single_cycle", 32'(err), 32'h0);
        check("req_ready_after", 32'(req_ready), 32'h1);
        check("valid_low_after", 32'(dout_valid), 32'h0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t vecs [6];
        int   e0;
        vecs[0] = '{idx: 2'd0, acc: 1'b1, stall: 1'b0, ok: 1'b1};
        vecs[1] = '{idx: 2'd1, acc: 1'b1, stall: 1'b1, ok: 1'b1};
        vecs[2] = '{idx: 2'd3, acc: 1'b1, stall: 1'b0, ok: 1'b0};
        vecs[3] = '{idx: 2'd2, acc: 1'b1, stall: 1'b0, ok: 1'b0};
        vecs[4] = '{idx: 2'd0, acc: 1'b0, stall: 1'b0, ok: 1'b0};
        vecs[5] = '{idx: 2'd1, acc: 1'b1, stall: 1'b0, ok: 1'b1};

        // Reset state
        @(posedge rom_clk); #1;
        @(posedge rom_clk); #1;
        mon_en = 1'b1;
        @(negedge rom_clk);
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_valid", 32'(dout_valid), 32'h0);
        check("rst_last", 32'(dout_last), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h1);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            do_req(vecs[i].idx, vecs[i].acc, vecs[i].stall, vecs[i].ok);
        end

        // Abort after 4567, then a follow-up request
        do_reset();
        @(posedge rom_clk); #1;
        req_valid  = 1'b1;
        req_idx    = 2'd0;
        acc_en     = 1'b1;
        dout_ready = 1'b1;
        exp_q.push_back('{d: 16'h0123, l: 1'b0});
        exp_q.push_back('{d: 16'h4567, l: 1'b0});
        @(posedge rom_clk); #1;
        req_valid = 1'b0;
        e0 = err_cnt;
        @(posedge rom_clk); #1;
        @(posedge rom_clk); #1;
        acc_en = 1'b0;
        @(negedge rom_clk);
        check("abort_pre_valid", 32'(dout_valid), 32'h1);
        @(negedge rom_clk);
        check("abort_valid", 32'(dout_valid), 32'h0);
        check("abort_dout", 32'(dout), 32'h0);
        check("abort_err", 32'(err), 32'h1);
        check("abort_words_seen", 32'(exp_q.size()), 32'h0);
        @(negedge rom_clk);
        check("abort_err_count", 32'(err_cnt - e0), 32'h1);
        exp_q.delete();
`ifdef KEYROM_LOCKOUT_EN
        do_req(2'd1, 1'b1, 1'b0, 1'b0);
`else
        do_req(2'd1, 1'b1, 1'b0, 1'b1);
`endif

        // Reset mid-stream, then a fresh idx 0 request
        do_reset();
        @(posedge rom_clk); #1;
        req_valid  = 1'b1;
        req_idx    = 2'd1;
        acc_en     = 1'b1;
        dout_ready = 1'b1;
        exp_q.push_back('{d: 16'hfedc, l: 1'b0});
        exp_q.push_back('{d: 16'hba98, l: 1'b0});
        @(posedge rom_clk); #1;
        req_valid = 1'b0;
        e0 = err_cnt;
        @(posedge rom_clk); #1;
        @(posedge rom_clk); #1;
        rom_rst_n = 1'b0;
        @(negedge rom_clk);
        @(negedge rom_clk);
        check("midrst_dout", 32'(dout), 32'h0);
        check("midrst_valid", 32'(dout_valid), 32'h0);
        check("midrst_last", 32'(dout_last), 32'h0);
        check("midrst_err", 32'(err), 32'h0);
        check("midrst_words_seen", 32'(exp_q.size()), 32'h0);
        @(posedge rom_clk); #1;
        rom_rst_n = 1'b1;
        @(negedge rom_clk);
        check("midrst_no_err_pulse", 32'(err_cnt - e0), 32'h0);
        check("midrst_req_ready", 32'(req_ready), 32'h1);
        exp_q.delete();
        do_req(2'd0, 1'b1, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
